// File: rtl/mc_seq_pkg.sv
// Shared types and opcode constants for the RV32I multi-cycle sequencer.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } seq_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/mc_opclass_dec.sv
// Combinational opcode classifier: legality, memory access and rd-write class.
module mc_opclass_dec
  import mc_seq_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_legal,
  output logic       o_is_mem,
  output logic       o_is_store,
  output logic       o_writes_rd
);

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    o_legal     = 1'b0;
    o_is_mem    = 1'b0;
    o_is_store  = 1'b0;
    o_writes_rd = 1'b0;
    case (i_opcode)
      OP_R, OP_IALU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
        o_legal     = 1'b1;
        o_writes_rd = 1'b1;
      end
      OP_LOAD: begin
        o_legal     = 1'b1;
        o_is_mem    = 1'b1;
        o_writes_rd = 1'b1;
      end
      OP_STORE: begin
        o_legal    = 1'b1;
        o_is_mem   = 1'b1;
        o_is_store = 1'b1;
      end
      OP_BRANCH: o_legal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Instruction-phase FSM owning all architectural write strobes, with
// halt / single-step / illegal-trap debug control and retire/cycle counters.
module mc_seq_ctrl
  import mc_seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             halt_req,
  input  logic             step,
  output logic             ir_we,
  output logic             mem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycles
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic             r_step_pend;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] r_cycles;

  logic w_legal;
  logic w_is_mem;
  logic w_is_store;
  logic w_writes_rd;

  mc_opclass_dec u_dec (
    .i_opcode    (opcode),
    .o_legal     (w_legal),
    .o_is_mem    (w_is_mem),
    .o_is_store  (w_is_store),
    .o_writes_rd (w_writes_rd)
  );

  always_comb begin
    w_next_state = r_state;
    ir_we        = 1'b0;
    mem_we       = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    case (r_state)
      S_IF: begin
        ir_we        = 1'b1;
        w_next_state = S_ID;
      end
      S_ID:  w_next_state = w_legal ? S_EX : S_HALT;
      S_EX:  w_next_state = w_is_mem ? S_MEM : S_WB;
      S_MEM: begin
        mem_we       = w_is_store;
        w_next_state = S_WB;
      end
      S_WB: begin
        pc_we        = 1'b1;
        rf_we        = w_writes_rd;
        w_next_state = (halt_req || r_step_pend) ? S_HALT : S_IF;
      end
      S_HALT: begin
        // A trapped core is frozen until reset; otherwise step beats a held halt.
        if (!r_illegal && (step || !halt_req)) w_next_state = S_IF;
      end
      default: w_next_state = S_IF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IF;
      r_step_pend <= 1'b0;
      r_illegal   <= 1'b0;
      r_instret   <= '0;
      r_cycles    <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_ID && !w_legal) r_illegal <= 1'b1;
      if (r_state == S_HALT && !r_illegal && step) r_step_pend <= 1'b1;
      else if (r_state == S_WB && w_next_state == S_HALT) r_step_pend <= 1'b0;
      if (r_state == S_WB) r_instret <= r_instret + CNT_W'(1);
      if (r_state != S_HALT) r_cycles <= r_cycles + CNT_W'(1);
    end
  end

  assign state   = r_state;
  assign halted  = (r_state == S_HALT);
  assign illegal = r_illegal;
  assign instret = r_instret;
  assign cycles  = r_cycles;

endmodule

// File: doc/mc_seq_ctrl.md
# mc_seq_ctrl

Multi-cycle sequencer for the RV32I datapath. Holds the instruction-phase state machine and drives the PC, instruction-register, data-memory and register-file write enables. Also implements halt, single-step and illegal-opcode trap control for the SDU debug flow, plus retired-instruction and cycle counters. It sits beside the decoder, takes the opcode field of the latched instruction, and owns every architectural write strobe.

## Interface
- `CNT_W`, default 32: width of the retired-instruction and cycle counters.
- `clk` input 1: CPU clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `opcode` input 7: `instr[6:0]` of the latched instruction register.
- `halt_req` input 1: level; request to stop at the next instruction boundary.
- `step` input 1: single-cycle pulse; execute exactly one instruction while halted.
- `ir_we` output 1: instruction register load enable.
- `mem_we` output 1: data memory write enable.
- `rf_we` output 1: register file write enable.
- `pc_we` output 1: PC update enable.
- `state` output 3: current state encoding, for the debug display.
- `halted` output 1: the FSM is in HALT.
- `illegal` output 1: sticky illegal-opcode trap flag.
- `instret` output CNT_W: count of retired instructions.
- `cycles` output CNT_W: count of non-halted cycles.

## Operation
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- Moore outputs are decoded from the state register only:
  - IF: `ir_we`=1.
  - MEM: `mem_we`=1 iff the opcode is STORE.
  - WB: `pc_we`=1; `rf_we`=1 iff the opcode class writes rd.
  - `halted`=1 in HALT.
- Opcode classes:
  - Writes rd: R (0110011), I-ALU (0010011), LOAD (0000011), LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111).
  - No rd write: STORE (0100011), BRANCH (1100011).
  - Any other opcode is illegal.
- Transitions:
  - IF→ID.
  - ID→EX if legal. ID→HALT with `illegal`:=1 if illegal; no write strobe is issued for that instruction.
  - EX→MEM for LOAD/STORE; EX→WB otherwise.
  - MEM→WB.
  - WB→HALT if `halt_req`=1 or `step_pend`=1; WB→IF otherwise. `instret` increments in WB.
  - HALT, when `illegal`=1: stay in HALT; `step` and `halt_req` are ignored until reset.
  - HALT, when `step`=1: go to IF and set `step_pend`.
  - HALT, when `halt_req`=0 and no step: go to IF.
  - `step` has priority over a deasserted `halt_req` in the same cycle.
- `step_pend` clears on the WB→HALT transition. A `step` pulse outside HALT is ignored.
- `cycles` increments every cycle the state is not HALT.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset values: state=IF, so `ir_we`=1. `mem_we`=`rf_we`=`pc_we`=0, `halted`=0, `illegal`=0, `step_pend`=0, `instret`=0, `cycles`=0.
- CPI: LOAD and STORE take 5 cycles; all other legal classes take 4.
- `opcode` is sampled in ID, EX, MEM and WB. It is stable from the cycle after IF until the next IF.
- `halt_req` is sampled only in WB. Asserting it mid-instruction never aborts the instruction.
- Resume latency: `halt_req` deasserted in cycle n (HALT) gives IF in n+1.
- Reset asserted mid-instruction: state is IF on the next edge, all strobes are 0 for the remainder of that instruction, and partial effects are discarded.

## Structure
- `mc_seq_pkg` holds:
  - the state enum `seq_state_t` (3-bit, encodings above);
  - the opcode localparams `OP_R`, `OP_IALU`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_JALR`, `OP_LUI`, `OP_AUIPC`.
- Sub-module `mc_opclass_dec` is combinational. It maps opcode → {`legal`, `is_mem`, `is_store`, `writes_rd`}.
- Counters and the FSM live in the top module.

## Test plan
- Reset, then opcode=0110011 held, `halt_req`=0 → strobe sequence `ir_we`, –, –, `rf_we`+`pc_we` repeating every 4 cycles; `instret`=3 after 12 cycles.
- opcode=0100011 → `mem_we`=1 only in cycle 4 of 5, `rf_we` never 1; opcode=0000011 → `rf_we`=1 in cycle 5, `mem_we`=0.
- `halt_req` raised during EX of an R-type → WB still retires (`instret`+1), then HALT with `halted`=1; `cycles` frozen over 10 halted cycles.
- While halted, one `step` pulse with a BRANCH opcode → IF, ID, EX, WB (`pc_we`=1, `rf_we`=0), then HALT; `instret`+1 exactly.
- opcode=1111111 → ID→HALT, `illegal`=1, no strobes; a following `step` and `halt_req`=0 leave it in HALT; `rst` clears `illegal` and returns to IF.
- `rst` asserted in MEM of a STORE → next cycle state=IF, `mem_we`=0, `instret` and `cycles`=0.
